// File: rtl/pipeline_wb.sv
// Writeback stage: aligns MEM-stage results with load latency, drives the regfile
// write port and forwarding tap, and commits traps. Optional macro: WB_RETIRE_COUNTER_EN.
module pipeline_wb #(
  parameter logic [31:0]  RESET_PC = 32'h0000_0000,
  parameter int unsigned  CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [31:0]      pc,
  input  logic [4:0]       rd_addr,
  input  logic [31:0]      rd_value,
  input  logic             memread_enable,
  input  logic             regwrite_enable,
  input  logic [2:0]       exception_in,
  input  logic [31:0]      mem_value,
  input  logic             exc_ack,
  output logic             has_final_exception,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd2_we,
  output logic [4:0]       fwd2_addr,
  output logic [31:0]      fwd2_data,
  output logic             exc_pending,
  output logic [31:0]      epc,
  output logic [2:0]       cause,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned EXC_W = 3;

  typedef enum logic {RUN, TRAP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [EXC_W-1:0]  cause_q, cause_d;

  logic              valid_q, memread_q, regwrite_q;
  logic [XLEN-1:0]   pc_q, rd_value_q;
  logic [RW-1:0]     rd_addr_q;
  logic [EXC_W-1:0]  exc_q;

  logic              fwd2_we_q;
  logic [RW-1:0]     fwd2_addr_q;
  logic [XLEN-1:0]   fwd2_data_q;

  logic              exc_d1;
  logic              commit;
  logic [XLEN-1:0]   wb_data;

  // Stage register; a flush (trap or ack) drops the incoming instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rd_addr_q  <= '0;
      rd_value_q <= '0;
      memread_q  <= 1'b0;
      regwrite_q <= 1'b0;
      exc_q      <= '0;
    end else begin
      valid_q    <= valid & (state_q == RUN) & ~exc_ack;
      pc_q       <= pc;
      rd_addr_q  <= rd_addr;
      rd_value_q <= rd_value;
      memread_q  <= memread_enable;
      regwrite_q <= regwrite_enable;
      exc_q      <= exception_in;
    end
  end

  assign exc_d1  = valid_q & (exc_q != '0);
  assign commit  = valid_q & (exc_q == '0) & (state_q == RUN);
  assign wb_data = memread_q ? mem_value : rd_value_q;

  assign rf_we               = commit & regwrite_q & (rd_addr_q != '0);
  assign rf_waddr            = rd_addr_q;
  assign rf_wdata            = wb_data;
  assign has_final_exception = (state_q == TRAP) | exc_d1;

  // Forwarding tap: one-cycle-old copy of the regfile write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd2_we_q   <= 1'b0;
      fwd2_addr_q <= '0;
      fwd2_data_q <= '0;
    end else begin
      fwd2_we_q   <= rf_we;
      fwd2_addr_q <= rf_waddr;
      fwd2_data_q <= rf_wdata;
    end
  end

  assign fwd2_we   = fwd2_we_q;
  assign fwd2_addr = fwd2_addr_q;
  assign fwd2_data = fwd2_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      epc_q   <= RESET_PC;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Trap FSM: first exception wins; a coincident ack discards it uncaptured.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      RUN: begin
        if (exc_d1 && !exc_ack) begin
          state_d = TRAP;
          epc_d   = pc_q;
          cause_d = exc_q;
        end
      end
      TRAP: begin
        if (exc_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign exc_pending = (state_q == TRAP);
  assign epc         = epc_q;
  assign cause       = cause_q;

`ifdef WB_RETIRE_COUNTER_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst)         retired_q <= '0;
    else if (commit) retired_q <= retired_q + CNT_W'(1);
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_wb.sv
// Directed bench for pipeline_wb: ALU/load writeback, r0, trap capture/ack,
// exception+ack collision and reset during trap.
module tb_pipeline_wb;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic [31:0]      pc;
  logic [4:0]       rd_addr;
  logic [31:0]      rd_value;
  logic             memread_enable;
  logic             regwrite_enable;
  logic [2:0]       exception_in;
  logic [31:0]      mem_value;
  logic             exc_ack;
  logic             has_final_exception;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             fwd2_we;
  logic [4:0]       fwd2_addr;
  logic [31:0]      fwd2_data;
  logic             exc_pending;
  logic [31:0]      epc;
  logic [2:0]       cause;
  logic [CNT_W-1:0] retired_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_retired = 0;

  pipeline_wb #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .pc(pc), .rd_addr(rd_addr),
    .rd_value(rd_value), .memread_enable(memread_enable),
    .regwrite_enable(regwrite_enable), .exception_in(exception_in),
    .mem_value(mem_value), .exc_ack(exc_ack),
    .has_final_exception(has_final_exception), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd2_we(fwd2_we),
    .fwd2_addr(fwd2_addr), .fwd2_data(fwd2_data), .exc_pending(exc_pending),
    .epc(epc), .cause(cause), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; pc = '0; rd_addr = '0; rd_value = '0; memread_enable = 1'b0;
    regwrite_enable = 1'b0; exception_in = '0; exc_ack = 1'b0;
  endtask

  task automatic issue(input logic [31:0] p, input logic [4:0] rd, input logic [31:0] v,
                       input logic mr, input logic [2:0] ex);
    valid = 1'b1; pc = p; rd_addr = rd; rd_value = v; memread_enable = mr;
    regwrite_enable = 1'b1; exception_in = ex;
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef WB_RETIRE_COUNTER_EN
    return CNT_W'(exp_retired);
`else
    return '0;
`endif
  endfunction

  task automatic test_reset();
    idle(); mem_value = '0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %0b exp 0", rf_we); else pass_cnt++;
    total_cnt++; if (fwd2_we !== 1'b0 || fwd2_addr !== 5'd0 || fwd2_data !== 32'd0)
      $display("FAIL reset_fwd2 got we=%0b a=%0d d=%h exp 0/0/0", fwd2_we, fwd2_addr, fwd2_data); else pass_cnt++;
    total_cnt++; if (exc_pending !== 1'b0 || cause !== 3'd0 || epc !== RESET_PC)
      $display("FAIL reset_trap got pend=%0b cause=%0d epc=%h exp 0/0/%h", exc_pending, cause, epc, RESET_PC); else pass_cnt++;
    total_cnt++; if (has_final_exception !== 1'b0) $display("FAIL reset_hfe got %0b exp 0", has_final_exception); else pass_cnt++;
    total_cnt++; if (retired_count !== exp_cnt()) $display("FAIL reset_count got %0d exp %0d", retired_count, exp_cnt()); else pass_cnt++;
  endtask

  task automatic test_alu_write();
    issue(32'h4, 5'd5, 32'h1234, 1'b0, 3'd0);
    tick(); idle(); exp_retired++;
    total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234)
      $display("FAIL alu_rf got we=%0b a=%0d d=%h exp 1/5/00001234", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
    tick();
    total_cnt++; if (fwd2_we !== 1'b1 || fwd2_addr !== 5'd5 || fwd2_data !== 32'h1234)
      $display("FAIL alu_fwd2 got we=%0b a=%0d d=%h exp 1/5/00001234", fwd2_we, fwd2_addr, fwd2_data); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL alu_idle_rf_we got %0b exp 0", rf_we); else pass_cnt++;
  endtask

  task automatic test_load();
    issue(32'h8, 5'd8, 32'h40, 1'b1, 3'd0);
    tick(); idle(); mem_value = 32'hDEAD_BEEF; exp_retired++;
    #1;
    total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'hDEAD_BEEF)
      $display("FAIL load_rf got we=%0b a=%0d d=%h exp 1/8/deadbeef", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
    tick(); mem_value = '0;
    total_cnt++; if (fwd2_we !== 1'b1 || fwd2_data !== 32'hDEAD_BEEF)
      $display("FAIL load_fwd2 got we=%0b d=%h exp 1/deadbeef", fwd2_we, fwd2_data); else pass_cnt++;
  endtask

  task automatic test_r0();
    issue(32'hC, 5'd0, 32'h99, 1'b0, 3'd0);
    tick(); idle(); exp_retired++;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL r0_rf_we got %0b exp 0", rf_we); else pass_cnt++;
    tick();
    total_cnt++; if (fwd2_we !== 1'b0) $display("FAIL r0_fwd2_we got %0b exp 0", fwd2_we); else pass_cnt++;
    total_cnt++; if (retired_count !== exp_cnt()) $display("FAIL r0_count got %0d exp %0d", retired_count, exp_cnt()); else pass_cnt++;
  endtask

  task automatic test_exception();
    issue(32'h100, 5'd7, 32'h77, 1'b0, 3'd3);
    tick();
    issue(32'h104, 5'd9, 32'h55, 1'b0, 3'd0);
    #1;
    total_cnt++; if (has_final_exception !== 1'b1 || rf_we !== 1'b0 || exc_pending !== 1'b0)
      $display("FAIL exc_d1 got hfe=%0b we=%0b pend=%0b exp 1/0/0", has_final_exception, rf_we, exc_pending); else pass_cnt++;
    tick();
    total_cnt++; if (epc !== 32'h100 || cause !== 3'd3 || exc_pending !== 1'b1)
      $display("FAIL exc_capture got epc=%h cause=%0d pend=%0b exp 100/3/1", epc, cause, exc_pending); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0 || has_final_exception !== 1'b1)
      $display("FAIL exc_trap_block got we=%0b hfe=%0b exp 0/1", rf_we, has_final_exception); else pass_cnt++;
    issue(32'h200, 5'd4, 32'h66, 1'b0, 3'd5);
    tick(); tick();
    total_cnt++; if (rf_we !== 1'b0 || epc !== 32'h100 || cause !== 3'd3)
      $display("FAIL exc_first_wins got we=%0b epc=%h cause=%0d exp 0/100/3", rf_we, epc, cause); else pass_cnt++;
    idle(); exc_ack = 1'b1;
    tick(); exc_ack = 1'b0;
    total_cnt++; if (exc_pending !== 1'b0 || has_final_exception !== 1'b0 || epc !== 32'h100)
      $display("FAIL exc_ack got pend=%0b hfe=%0b epc=%h exp 0/0/100", exc_pending, has_final_exception, epc); else pass_cnt++;
    issue(32'h300, 5'd10, 32'hA5, 1'b0, 3'd0);
    tick(); idle(); exp_retired++;
    total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA5)
      $display("FAIL exc_resume got we=%0b a=%0d d=%h exp 1/10/000000a5", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_simultaneous();
    issue(32'h400, 5'd6, 32'h11, 1'b0, 3'd2);
    tick();
    issue(32'h404, 5'd11, 32'h22, 1'b0, 3'd0);
    exc_ack = 1'b1;
    #1;
    total_cnt++; if (rf_we !== 1'b0 || has_final_exception !== 1'b1)
      $display("FAIL sim_d1 got we=%0b hfe=%0b exp 0/1", rf_we, has_final_exception); else pass_cnt++;
    tick(); idle();
    total_cnt++; if (exc_pending !== 1'b0 || cause !== 3'd3 || epc !== 32'h100)
      $display("FAIL sim_no_capture got pend=%0b cause=%0d epc=%h exp 0/3/100", exc_pending, cause, epc); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL sim_flush got we=%0b exp 0", rf_we); else pass_cnt++;
    issue(32'h408, 5'd12, 32'h77, 1'b0, 3'd0);
    tick(); idle(); exp_retired++;
    total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h77)
      $display("FAIL sim_resume got we=%0b a=%0d d=%h exp 1/12/00000077", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
    tick();
    total_cnt++; if (retired_count !== exp_cnt()) $display("FAIL sim_count got %0d exp %0d", retired_count, exp_cnt()); else pass_cnt++;
  endtask

  task automatic test_reset_trap();
    issue(32'h500, 5'd2, 32'h33, 1'b0, 3'd1);
    tick(); idle(); tick();
    total_cnt++; if (exc_pending !== 1'b1 || epc !== 32'h500 || cause !== 3'd1)
      $display("FAIL rtrap_enter got pend=%0b epc=%h cause=%0d exp 1/500/1", exc_pending, epc, cause); else pass_cnt++;
    rst = 1'b1;
    tick(); rst = 1'b0; exp_retired = 0;
    total_cnt++; if (exc_pending !== 1'b0 || epc !== RESET_PC || cause !== 3'd0)
      $display("FAIL rtrap_state got pend=%0b epc=%h cause=%0d exp 0/%h/0", exc_pending, epc, cause, RESET_PC); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0 || has_final_exception !== 1'b0 || fwd2_we !== 1'b0)
      $display("FAIL rtrap_outs got we=%0b hfe=%0b fwe=%0b exp 0/0/0", rf_we, has_final_exception, fwd2_we); else pass_cnt++;
    total_cnt++; if (retired_count !== exp_cnt()) $display("FAIL rtrap_count got %0d exp %0d", retired_count, exp_cnt()); else pass_cnt++;
    issue(32'h600, 5'd3, 32'h9, 1'b0, 3'd0);
    tick(); idle();
    total_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h9)
      $display("FAIL rtrap_resume got we=%0b a=%0d d=%h exp 1/3/00000009", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load();
    test_r0();
    test_exception();
    test_simultaneous();
    test_reset_trap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
